// File: rtl/pipe_sel_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_sel_mux_if
// Brief    : Handshake/data bundle for the pipe_sel_mux operand-select stage.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_sel_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    logic [WIDTH*NUM_IN-1:0] in_bus;
    logic [NUM_IN-2:0]       sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sel_err;
    logic                    err_clr;
    logic [7:0]              err_cnt;

    // Upstream/downstream environment around the stage
    modport master (
        output in_bus, sel, in_valid, flush, out_ready, err_clr,
        input  in_ready, out_data, out_valid, out_sel_err, err_cnt
    );

    // The select stage itself
    modport slave (
        input  in_bus, sel, in_valid, flush, out_ready, err_clr,
        output in_ready, out_data, out_valid, out_sel_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_sel_mux.sv
`default_nettype none
// ============================================================================
// Module   : pipe_sel_mux
// Brief    : Registered one-hot operand select with valid/ready, flush and
//            illegal-select tagging. Define SEL_ERR_CNT_EN for the counter.
// Revision : 1.0  initial release
// ============================================================================
module pipe_sel_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pipe_sel_mux_if.slave   bus
);
    localparam int         c_SEL_W   = NUM_IN - 1;
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_illegal;
    logic             w_in_ready;
    logic             w_acc;

    logic             out_valid_q,   out_valid_d;
    logic [WIDTH-1:0] out_data_q,    out_data_d;
    logic             out_sel_err_q, out_sel_err_d;

    // Illegal codes (two or more bits set) fall back to input 0.
    always_comb begin
        w_sel_data    = bus.in_bus[WIDTH-1:0];
        w_sel_illegal = !$onehot0(bus.sel);
        if (!w_sel_illegal) begin
            for (int j = 0; j < c_SEL_W; j++) begin
                if (bus.sel[j]) begin
                    w_sel_data = bus.in_bus[(j+1)*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign w_in_ready = !out_valid_q || bus.out_ready;
    assign w_acc      = bus.in_valid && w_in_ready && !bus.flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sel_err_d = out_sel_err_q;
        if (bus.flush) begin
            out_valid_d   = 1'b0;
            out_sel_err_d = 1'b0;
        end else if (w_acc) begin
            out_valid_d   = 1'b1;
            out_data_d    = w_sel_data;
            out_sel_err_d = w_sel_illegal;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sel_err_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sel_err_q <= out_sel_err_d;
        end
    end

`ifdef SEL_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // A clear that coincides with an illegal accept leaves that beat counted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = (w_acc && w_sel_illegal) ? 8'd1 : 8'd0;
        end else if (w_acc && w_sel_illegal && (err_cnt_q != c_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.err_cnt    = 8'd0;
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_sel_err = out_sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sel_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_sel_mux
// Brief    : Randomized + directed scoreboard bench for pipe_sel_mux.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_sel_mux;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = NUM_IN - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_sel_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

    pipe_sel_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [WIDTH:0] sb[$];          // {illegal, data} of each accepted beat
    logic           m_valid = 1'b0;
    int             m_cnt   = 0;
    logic           exp_ready = 1'b1;
    logic           started   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: count set bits; exactly one bit j selects input j+1.
    function automatic void ref_decode(input logic [SEL_W-1:0] s,
                                       input logic [NUM_IN*WIDTH-1:0] b,
                                       output logic [WIDTH-1:0] d,
                                       output logic ill);
        int ones = 0;
        int pos  = 0;
        for (int j = 0; j < SEL_W; j++) begin
            if (s[j]) begin
                ones++;
                pos = j + 1;
            end
        end
        ill = (ones > 1);
        d   = (ones == 1) ? b[pos*WIDTH +: WIDTH] : b[WIDTH-1:0];
    endfunction

    function automatic logic [NUM_IN*WIDTH-1:0] rand_bus();
        logic [NUM_IN*WIDTH-1:0] b;
        for (int k = 0; k < NUM_IN; k++) b[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return b;
    endfunction

    // One clock of stimulus, entered and left 1 ns after a rising edge.
    task automatic step(input logic v, input logic [SEL_W-1:0] s,
                        input logic [NUM_IN*WIDTH-1:0] b, input logic f,
                        input logic ordy, input logic clr, input logic r);
        logic [WIDTH-1:0] d;
        logic             ill;
        logic             acc;
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("err_cnt",   64'(bus.err_cnt),   64'(m_cnt));
        bus.in_valid  = v;
        bus.sel       = s;
        bus.in_bus    = b;
        bus.flush     = f;
        bus.out_ready = ordy;
        bus.err_clr   = clr;
        rst           = r;
        exp_ready     = !m_valid || ordy;
        ref_decode(s, b, d, ill);
        acc = v && exp_ready && !f;
        if (r) begin
            m_valid = 1'b0;
            m_cnt   = 0;
            sb.delete();
        end else begin
            if (f) begin
                if (m_valid && !ordy) void'(sb.pop_back());
                m_valid = 1'b0;
            end else if (acc) begin
                sb.push_back({ill, d});
                m_valid = 1'b1;
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
`ifdef SEL_ERR_CNT_EN
            if (clr) m_cnt = (acc && ill) ? 1 : 0;
            else if (acc && ill && m_cnt < 255) m_cnt++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares every beat the DUT hands downstream.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    logic [WIDTH:0] e;
                    e = sb.pop_front();
                    chk("out_data",    64'(bus.out_data),    64'(e[WIDTH-1:0]));
                    chk("out_sel_err", 64'(bus.out_sel_err), 64'(e[WIDTH]));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        logic [NUM_IN*WIDTH-1:0] kb;
        kb = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        bus.in_valid = 1'b0; bus.sel = '0; bus.in_bus = '0; bus.flush = 1'b0;
        bus.out_ready = 1'b0; bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        chk("rst_out_valid",   64'(bus.out_valid),   64'(0));
        chk("rst_out_data",    64'(bus.out_data),    64'(0));
        chk("rst_out_sel_err", 64'(bus.out_sel_err), 64'(0));
        chk("rst_err_cnt",     64'(bus.err_cnt),     64'(0));
        chk("rst_in_ready",    64'(bus.in_ready),    64'(1));

        // Legal sweep then illegal code 011
        step(1, 3'b000, kb, 0, 1, 0, 0);
        step(1, 3'b001, kb, 0, 1, 0, 0);
        step(1, 3'b010, kb, 0, 1, 0, 0);
        step(1, 3'b100, kb, 0, 1, 0, 0);
        chk("sweep_last", 64'(bus.out_data), 64'(32'hDDDD0003));
        step(1, 3'b011, kb, 0, 1, 0, 0);
        chk("illegal_data", 64'(bus.out_data),    64'(32'hAAAA0000));
        chk("illegal_flag", 64'(bus.out_sel_err), 64'(1));
        step(0, 3'b000, kb, 0, 1, 0, 0);

        // Backpressure: hold one beat for 3 cycles with new data offered
        step(1, 3'b001, kb, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 3'b010, rand_bus(), 0, 0, 0, 0);
        chk("stall_hold", 64'(bus.out_data), 64'(32'hBBBB0001));
        step(1, 3'b100, kb, 0, 1, 0, 0);
        step(0, 3'b000, kb, 0, 1, 0, 0);

        // Flush while holding a beat, with a new beat offered
        step(1, 3'b010, kb, 0, 0, 0, 0);
        step(1, 3'b100, kb, 1, 0, 0, 0);
        step(1, 3'b001, kb, 0, 1, 0, 0);
        step(0, 3'b000, kb, 0, 1, 0, 0);

        // Saturation, then clear coinciding with an illegal accept
        for (int i = 0; i < 260; i++) step(1, 3'b111, rand_bus(), 0, 1, 0, 0);
        step(1, 3'b101, kb, 0, 1, 1, 0);
        step(0, 3'b000, kb, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [SEL_W-1:0] s;
            if ($urandom_range(0, 9) < 7) begin
                int p;
                p = $urandom_range(0, SEL_W);
                s = (p == 0) ? '0 : SEL_W'(1 << (p - 1));
            end else begin
                s = SEL_W'($urandom);
            end
            step(($urandom_range(0, 3) != 0), s, rand_bus(),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0), 1'b0);
        end

        // Reset in the middle of a stall with err_cnt at 5
        step(1, 3'b011, kb, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 3'b110, kb, 0, 1, 0, 0);
        step(1, 3'b010, kb, 0, 0, 0, 0);
        step(1, 3'b001, kb, 0, 0, 0, 0);
        step(1, 3'b001, kb, 0, 0, 0, 1);
        chk("mid_rst_out_valid", 64'(bus.out_valid),   64'(0));
        chk("mid_rst_out_data",  64'(bus.out_data),    64'(0));
        chk("mid_rst_sel_err",   64'(bus.out_sel_err), 64'(0));
        chk("mid_rst_err_cnt",   64'(bus.err_cnt),     64'(0));
        chk("mid_rst_in_ready",  64'(bus.in_ready),    64'(1));
        step(1, 3'b100, kb, 0, 1, 0, 0);
        step(0, 3'b000, kb, 0, 1, 0, 0);
        step(0, 3'b000, kb, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
